csr_exec_unit: RTL and testbench
================================

// Module: csr_exec_unit
// PURPOSE
//  Executes CSR instructions (CSRRW/RS/RC and immediate forms) one at a time, as a read-modify-write sequencer.
//  Sits upstream of csr_regs_if/csr_regs: takes a decoded SYSTEM op from decode, reads the CSR,
//  computes the new value and issues the write. Returns the old CSR value to register writeback.
// PARAMETERS
//  XLEN        32  data width
//  CSR_AW      12  CSR address width
//  RF_AW        5  register index / uimm width
// PORTS
//  clk            in   1       system clock
//  rst            in   1       reset; one clock; reset is asynchronous and active-high
//  halt           in   1       pipeline halt: freezes FSM, suppresses csr_write_en
//  req_valid      in   1       decoded CSR op present
//  req_ready      out  1       unit accepts op this cycle
//  req_funct3     in   3       CSR funct3 (001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI)
//  req_csr_addr   in   CSR_AW  target CSR
//  req_rs1_idx    in   RF_AW   rs1 field (also uimm for immediate forms)
//  req_rs1_data   in   XLEN    rs1 register value
//  req_rd_addr    in   RF_AW   destination register
//  csr_read_en    out  1       read strobe to CSR file
//  csr_read_addr  out  CSR_AW  read address
//  csr_read_data  in   XLEN    CSR data, valid one cycle after csr_read_en
//  csr_write_en   out  1       write strobe, single-cycle
//  csr_write_addr out  CSR_AW  write address
//  csr_write_data out  XLEN    new CSR value
//  wb_valid       out  1       writeback result valid
//  wb_ready       in   1       writeback accepts result
//  wb_rd_addr     out  RF_AW   destination register
//  wb_data        out  XLEN    old CSR value
//  illegal        out  1       one-cycle pulse: illegal CSR op
// BEHAVIOUR
//  Reset: state=IDLE; every output 0 except req_ready (=1 when !halt). Request/old-value regs cleared.
//  States: IDLE -> READ -> CAPT -> WRITE -> RESP -> IDLE.
//  IDLE: req_ready = !halt. On req_valid&req_ready latch funct3, addr, rd, operand; go READ.
//    operand = funct3[2] ? zero-extended req_rs1_idx : req_rs1_data.
//  READ: csr_read_en=1, csr_read_addr=latched addr; go CAPT.
//  CAPT: old_q <= csr_read_data; decide wr_req and illegal; go WRITE if legal, else IDLE with illegal=1.
//  wr_req: RW/RWI always; RS/RC/RSI/RCI only if latched rs1_idx/uimm != 0.
//  Illegal: funct3 in {000,100}, or wr_req with addr[11:10]==2'b11 (read-only). No write, no wb.
//  WRITE: csr_write_en = wr_req & !halt, for exactly one cycle; go RESP when !halt.
//    new = RW: operand; RS: old_q|operand; RC: old_q&~operand. Full XLEN, no sign extension.
//    csr_write_data/addr held stable throughout WRITE.
//  RESP: wb_valid=1, wb_data=old_q, wb_rd_addr=latched rd (rd==x0 still reported);
//    hold until wb_ready; on wb_valid&wb_ready go IDLE. Next accept earliest the following cycle.
//  Latency: accept at cycle 0 -> read at 1 -> capture at 2 -> write at 3 -> wb_valid at 4.
//  halt: any state holds (no transition, no handshake); csr_read_en held in READ (re-read is harmless);
//    csr_write_en forced 0. Release resumes exactly where stalled; write issued once.
//  Reset mid-operation: abandon op, IDLE next; partially issued write never repeated/completed.
//  Inputs req_* ignored outside IDLE; wb_ready ignored outside RESP.
// TESTING
//  CSRRW 0x340, old 0, rs1_data 0xDEADBEEF -> write_en@c3 data 0xDEADBEEF; wb_data 0x0 @c4.
//  CSRRS 0x340, rs1_idx 0, old 0x12345678 -> no write_en; wb_data 0x12345678.
//  CSRRCI 0x300, uimm 5'b00101, old 0xFF -> write_data 0xFA; wb_data 0xFF.
//  CSRRW 0xF14 -> illegal pulse @c2, no write, no wb_valid, req_ready back @c3.
//  halt 3 cycles during WRITE + wb_ready low 2 cycles -> one write_en pulse, wb held stable.
//  rst asserted in CAPT -> outputs 0 next cycle; new CSRRW then completes normally.

Source files
------------

// File: rtl/csr_exec_unit.sv
// CSR read-modify-write sequencer: reads the target CSR, computes the new value
// for RW/RS/RC (register and immediate forms), issues one write, returns the old value.
module csr_exec_unit #(
   parameter int XLEN   = 32,
   parameter int CSR_AW = 12,
   parameter int RF_AW  = 5
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_halt,
   input  logic              i_req_valid,
   output logic              o_req_ready,
   input  logic [2:0]        i_req_funct3,
   input  logic [CSR_AW-1:0] i_req_csr_addr,
   input  logic [RF_AW-1:0]  i_req_rs1_idx,
   input  logic [XLEN-1:0]   i_req_rs1_data,
   input  logic [RF_AW-1:0]  i_req_rd_addr,
   output logic              o_csr_read_en,
   output logic [CSR_AW-1:0] o_csr_read_addr,
   input  logic [XLEN-1:0]   i_csr_read_data,
   output logic              o_csr_write_en,
   output logic [CSR_AW-1:0] o_csr_write_addr,
   output logic [XLEN-1:0]   o_csr_write_data,
   output logic              o_wb_valid,
   input  logic              i_wb_ready,
   output logic [RF_AW-1:0]  o_wb_rd_addr,
   output logic [XLEN-1:0]   o_wb_data,
   output logic              o_illegal
);

   // state   | meaning
   // S_IDLE  | ready for a new op
   // S_READ  | read strobe to CSR file
   // S_CAPT  | capture old value, legality check
   // S_WRITE | single write strobe (if needed)
   // S_RESP  | old value offered to writeback
   typedef enum logic [2:0] {S_IDLE, S_READ, S_CAPT, S_WRITE, S_RESP} state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [2:0]          r_funct3;
   logic [CSR_AW-1:0]   r_addr;
   logic [RF_AW-1:0]    r_rd;
   logic [RF_AW-1:0]    r_idx;
   logic [XLEN-1:0]     r_operand;
   logic [XLEN-1:0]     r_old;
   logic                r_wr_req;

   logic                w_accept;
   logic                w_wr_req;
   logic                w_illegal_op;
   logic [XLEN-1:0]     w_operand_in;
   logic [XLEN-1:0]     w_new_val;

   assign w_accept     = (r_state == S_IDLE) && i_req_valid && !i_halt;
   assign w_operand_in = i_req_funct3[2] ? {{(XLEN-RF_AW){1'b0}}, i_req_rs1_idx} : i_req_rs1_data;

   // set/clear with a zero source is a pure read and must not touch read-only CSRs
   assign w_wr_req     = (r_funct3[1:0] == 2'b01) || (r_idx != '0);
   assign w_illegal_op = (r_funct3[1:0] == 2'b00) ||
                         (w_wr_req && (r_addr[CSR_AW-1 -: 2] == 2'b11));

   always_comb begin
      w_new_val = r_old & ~r_operand;
      case (r_funct3[1:0])
         2'b01:   w_new_val = r_operand;
         2'b10:   w_new_val = r_old | r_operand;
         default: w_new_val = r_old & ~r_operand;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state   <= S_IDLE;
         r_funct3  <= '0;
         r_addr    <= '0;
         r_rd      <= '0;
         r_idx     <= '0;
         r_operand <= '0;
         r_old     <= '0;
         r_wr_req  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_funct3  <= i_req_funct3;
            r_addr    <= i_req_csr_addr;
            r_rd      <= i_req_rd_addr;
            r_idx     <= i_req_rs1_idx;
            r_operand <= w_operand_in;
         end
         // read data is only valid the cycle after the strobe, so capture on the advancing edge
         if ((r_state == S_CAPT) && !i_halt) begin
            r_old    <= i_csr_read_data;
            r_wr_req <= w_wr_req;
         end
      end
   end

   always_comb begin
      w_state_nxt      = r_state;
      o_req_ready      = 1'b0;
      o_csr_read_en    = 1'b0;
      o_csr_read_addr  = '0;
      o_csr_write_en   = 1'b0;
      o_csr_write_addr = '0;
      o_csr_write_data = '0;
      o_wb_valid       = 1'b0;
      o_wb_rd_addr     = '0;
      o_wb_data        = '0;
      o_illegal        = 1'b0;
      case (r_state)
         S_IDLE: begin
            o_req_ready = !i_halt;
            if (w_accept) w_state_nxt = S_READ;
         end
         S_READ: begin
            o_csr_read_en   = 1'b1;
            o_csr_read_addr = r_addr;
            if (!i_halt) w_state_nxt = S_CAPT;
         end
         S_CAPT: begin
            if (!i_halt) begin
               o_illegal   = w_illegal_op;
               w_state_nxt = w_illegal_op ? S_IDLE : S_WRITE;
            end
         end
         S_WRITE: begin
            o_csr_write_en   = r_wr_req && !i_halt;
            o_csr_write_addr = r_addr;
            o_csr_write_data = w_new_val;
            if (!i_halt) w_state_nxt = S_RESP;
         end
         S_RESP: begin
            o_wb_valid   = 1'b1;
            o_wb_rd_addr = r_rd;
            o_wb_data    = r_old;
            if (i_wb_ready && !i_halt) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_csr_exec_unit.sv
// Directed bench for csr_exec_unit: a CSR file model plus a per-op behavioural
// expectation checked every cycle, with literal values pinning key results.
module tb_csr_exec_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        halt = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [2:0]  req_funct3 = '0;
   logic [11:0] req_csr_addr = '0;
   logic [4:0]  req_rs1_idx = '0;
   logic [31:0] req_rs1_data = '0;
   logic [4:0]  req_rd_addr = '0;
   logic        csr_read_en;
   logic [11:0] csr_read_addr;
   logic [31:0] csr_read_data = '0;
   logic        csr_write_en;
   logic [11:0] csr_write_addr;
   logic [31:0] csr_write_data;
   logic        wb_valid;
   logic        wb_ready = 1'b0;
   logic [4:0]  wb_rd_addr;
   logic [31:0] wb_data;
   logic        illegal;

   int nvec = 0;
   int nerr = 0;

   logic [31:0] csr_mem [0:4095];
   bit          chk_en = 1'b0;
   bit          exp_wr, exp_ill;
   logic [11:0] exp_addr;
   logic [31:0] exp_data, exp_old;
   logic [4:0]  exp_rd;

   csr_exec_unit dut (
      .i_clk(clk), .i_rst(rst), .i_halt(halt),
      .i_req_valid(req_valid), .o_req_ready(req_ready),
      .i_req_funct3(req_funct3), .i_req_csr_addr(req_csr_addr),
      .i_req_rs1_idx(req_rs1_idx), .i_req_rs1_data(req_rs1_data),
      .i_req_rd_addr(req_rd_addr),
      .o_csr_read_en(csr_read_en), .o_csr_read_addr(csr_read_addr),
      .i_csr_read_data(csr_read_data),
      .o_csr_write_en(csr_write_en), .o_csr_write_addr(csr_write_addr),
      .o_csr_write_data(csr_write_data),
      .o_wb_valid(wb_valid), .i_wb_ready(wb_ready),
      .o_wb_rd_addr(wb_rd_addr), .o_wb_data(wb_data),
      .o_illegal(illegal)
   );

   always #5 clk = ~clk;

   // CSR file: registered read on strobe, write on strobe
   always @(posedge clk) begin
      if (csr_read_en) csr_read_data <= csr_mem[csr_read_addr];
      if (csr_write_en) csr_mem[csr_write_addr] = csr_write_data;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      nvec++;
      if (act !== req) begin
         nerr++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en && !rst) begin
         if (csr_write_en) begin
            chk("write_allowed", 32'(exp_wr), 32'd1);
            chk("write_addr", 32'(csr_write_addr), 32'(exp_addr));
            chk("write_data", csr_write_data, exp_data);
         end
         if (wb_valid) begin
            chk("wb_data", wb_data, exp_old);
            chk("wb_rd", 32'(wb_rd_addr), 32'(exp_rd));
         end
         if (illegal) chk("illegal_allowed", 32'(exp_ill), 32'd1);
      end
   end

   task automatic run_op(input string tag, input logic [2:0] f3, input logic [11:0] a,
                         input logic [4:0] idx, input logic [31:0] d, input logic [4:0] rd,
                         input int h, input int dly,
                         input bit pw, input logic [31:0] pwv,
                         input bit pb, input logic [31:0] pbv);
      logic [31:0] old, opnd, nv, last_wr, last_wb;
      bit wr, ill, done;
      int first_rd, first_ill, first_wr, first_wb, wr_cnt, ill_cnt;
      old  = csr_mem[a];
      opnd = f3[2] ? {27'b0, idx} : d;
      wr   = (f3[1:0] == 2'b01) || (idx != 5'd0);
      ill  = (f3[1:0] == 2'b00) || (wr && a[11:10] == 2'b11);
      case (f3[1:0])
         2'b01:   nv = opnd;
         2'b10:   nv = old | opnd;
         default: nv = old & ~opnd;
      endcase
      exp_wr = wr && !ill; exp_ill = ill; exp_addr = a; exp_data = nv;
      exp_rd = rd; exp_old = old; chk_en = 1'b1;
      first_rd = -1; first_ill = -1; first_wr = -1; first_wb = -1;
      wr_cnt = 0; ill_cnt = 0; done = 1'b0; last_wr = '0; last_wb = '0;

      @(posedge clk); #1;
      req_valid = 1'b1; req_funct3 = f3; req_csr_addr = a;
      req_rs1_idx = idx; req_rs1_data = d; req_rd_addr = rd;
      halt = 1'b0; wb_ready = 1'b0;
      @(negedge clk);
      chk({tag, "/accept_ready"}, 32'(req_ready), 32'd1);

      for (int c = 1; c <= 30; c++) begin
         @(posedge clk); #1;
         // garbage requests while busy must be ignored
         req_valid    = (c <= 2);
         req_funct3   = (c <= 2) ? 3'b001 : 3'b000;
         req_csr_addr = (c <= 2) ? ~a : 12'h0;
         req_rs1_idx  = (c <= 2) ? ~idx : 5'h0;
         req_rs1_data = (c <= 2) ? ~d : 32'h0;
         req_rd_addr  = (c <= 2) ? ~rd : 5'h0;
         halt         = (c >= 3) && (c < 3 + h);
         wb_ready     = (c >= 4 + h + dly);
         @(negedge clk);
         if (csr_read_en && first_rd < 0) first_rd = c;
         if (illegal) begin ill_cnt++; first_ill = c; end
         if (csr_write_en) begin wr_cnt++; first_wr = c; last_wr = csr_write_data; end
         if (wb_valid) begin
            if (first_wb < 0) first_wb = c;
            last_wb = wb_data;
            if (wb_ready) done = 1'b1;
         end
         if (ill && c == 3) begin
            chk({tag, "/ready_after_illegal"}, 32'(req_ready), 32'd1);
            done = 1'b1;
         end
         if (done) break;
      end
      req_valid = 1'b0;

      chk({tag, "/completed"}, 32'(done), 32'd1);
      chk({tag, "/read_cycle"}, 32'(first_rd), 32'd1);
      if (ill) begin
         chk({tag, "/illegal_pulses"}, 32'(ill_cnt), 32'd1);
         chk({tag, "/illegal_cycle"}, 32'(first_ill), 32'd2);
         chk({tag, "/writes"}, 32'(wr_cnt), 32'd0);
         chk({tag, "/wb_seen"}, 32'(first_wb), 32'hFFFF_FFFF);
      end else begin
         chk({tag, "/illegal_pulses"}, 32'(ill_cnt), 32'd0);
         chk({tag, "/writes"}, 32'(wr_cnt), 32'(wr));
         if (wr) chk({tag, "/write_cycle"}, 32'(first_wr), 32'(3 + h));
         chk({tag, "/wb_cycle"}, 32'(first_wb), 32'(4 + h));
         if (pw) chk({tag, "/pin_write"}, last_wr, pwv);
         if (pb) chk({tag, "/pin_wb"}, last_wb, pbv);
         @(posedge clk); #1;
         wb_ready = 1'b0;
         @(negedge clk);
         chk({tag, "/ready_after_wb"}, 32'(req_ready), 32'd1);
         chk({tag, "/wb_dropped"}, 32'(wb_valid), 32'd0);
      end
      chk_en = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 4096; i++) csr_mem[i] = 32'h0;
      csr_mem[12'h300] = 32'h0000_00FF;
      csr_mem[12'h305] = 32'h8000_0000;
      csr_mem[12'h341] = 32'h0000_1234;
      csr_mem[12'hC00] = 32'hAAAA_5555;
      csr_mem[12'hF14] = 32'h0000_0007;
      rst = 1'b1;
      #1;
      chk("reset_ready", 32'(req_ready), 32'd1);
      chk("reset_wb_valid", 32'(wb_valid), 32'd0);
      chk("reset_write_en", 32'(csr_write_en), 32'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      run_op("rw_340",   3'b001, 12'h340, 5'd1,  32'hDEADBEEF, 5'd1, 0, 0, 1, 32'hDEADBEEF, 1, 32'h0);
      csr_mem[12'h340] = 32'h1234_5678;
      run_op("rs_zero",  3'b010, 12'h340, 5'd0,  32'hFFFFFFFF, 5'd2, 0, 0, 0, 32'h0, 1, 32'h1234_5678);
      run_op("rci_300",  3'b111, 12'h300, 5'd5,  32'h0,        5'd3, 0, 0, 1, 32'hFA, 1, 32'hFF);
      run_op("rw_f14",   3'b001, 12'hF14, 5'd1,  32'h1,        5'd4, 0, 0, 0, 32'h0, 0, 32'h0);
      run_op("rs_halt",  3'b010, 12'h340, 5'd7,  32'h0000_00F0, 5'd5, 3, 2, 1, 32'h1234_56F8, 1, 32'h1234_5678);
      run_op("rc_340",   3'b011, 12'h340, 5'd9,  32'hFFFF_0000, 5'd6, 0, 0, 1, 32'h0000_56F8, 1, 32'h1234_56F8);
      run_op("rsi_305",  3'b110, 12'h305, 5'd31, 32'h0,        5'd7, 0, 0, 1, 32'h8000_001F, 1, 32'h8000_0000);
      run_op("rwi_zero", 3'b101, 12'h341, 5'd0,  32'hFFFFFFFF, 5'd8, 0, 1, 1, 32'h0, 1, 32'h1234);
      run_op("f3_000",   3'b000, 12'h340, 5'd1,  32'h1,        5'd9, 0, 0, 0, 32'h0, 0, 32'h0);
      run_op("f3_100",   3'b100, 12'h340, 5'd1,  32'h1,        5'd9, 0, 0, 0, 32'h0, 0, 32'h0);
      run_op("rs_ro_rd", 3'b010, 12'hC00, 5'd0,  32'h1,        5'd0, 0, 0, 0, 32'h0, 1, 32'hAAAA_5555);
      run_op("rci_ro",   3'b111, 12'hC01, 5'd1,  32'h0,        5'd10, 0, 0, 0, 32'h0, 0, 32'h0);
      chk("mem_c00_untouched", csr_mem[12'hC00], 32'hAAAA_5555);
      chk("mem_340_final", csr_mem[12'h340], 32'h0000_56F8);

      // reset while capturing: abandon op, nothing written
      csr_mem[12'h340] = 32'h1111_1111;
      exp_wr = 1'b0; exp_ill = 1'b0; chk_en = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b1; req_funct3 = 3'b001; req_csr_addr = 12'h340;
      req_rs1_idx = 5'd1; req_rs1_data = 32'h2222_2222; req_rd_addr = 5'd1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      chk("rst_read_en", 32'(csr_read_en), 32'd0);
      chk("rst_write_en", 32'(csr_write_en), 32'd0);
      chk("rst_write_data", csr_write_data, 32'd0);
      chk("rst_wb_valid", 32'(wb_valid), 32'd0);
      chk("rst_wb_data", wb_data, 32'd0);
      chk("rst_illegal", 32'(illegal), 32'd0);
      chk("rst_ready", 32'(req_ready), 32'd1);
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_no_write", csr_mem[12'h340], 32'h1111_1111);
      chk_en = 1'b0;
      run_op("rw_after_rst", 3'b001, 12'h340, 5'd1, 32'h3333_3333, 5'd11, 0, 0, 1, 32'h3333_3333, 1, 32'h1111_1111);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
